// File: rtl/hash_seq_pkg.sv
// Shared types and defaults for the hash sequencer slice.
// Build option: HASH_SEQ_LEN_PAD_EN enables the length-padding phase.
package hash_seq_pkg;

    localparam int PHASE_W    = 16;
    localparam int CFG_W_DEF  = 32;
    localparam int OUT_W_DEF  = 32;
    localparam int WARMUP_DEF = 64;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CONFIG,
        ST_ABSORB,
        ST_PAD,
        ST_WARMUP,
        ST_SQUEEZE
    } state_e;

endpackage

// File: rtl/hash_seq_if.sv
// Host-side bundle of the hash sequencer: request, message stream,
// digest stream and status.
interface hash_seq_if
    import hash_seq_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);

    logic             start;
    logic [CFG_W-1:0] cfg_word;
    logic             busy;
    logic             msg_valid;
    logic             msg_bit;
    logic             msg_last;
    logic             msg_ready;
    logic [OUT_W-1:0] digest;
    logic             digest_valid;
    logic             digest_ready;
    logic [LEN_W-1:0] bit_count;

    modport master (
        output start, cfg_word,
        output msg_valid, msg_bit, msg_last,
        output digest_ready,
        input  busy, msg_ready,
        input  digest, digest_valid, bit_count
    );

    modport slave (
        input  start, cfg_word,
        input  msg_valid, msg_bit, msg_last,
        input  digest_ready,
        output busy, msg_ready,
        output digest, digest_valid, bit_count
    );

endinterface

// File: rtl/hash_seq_shifter.sv
// Config shadow register: parallel load on request, serial out LSB first.
module hash_seq_shifter
    import hash_seq_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CFG_W-1:0] load_word,
    input  logic             shift,
    output logic             sbit
);

    logic [CFG_W-1:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (load) begin
            shadow_q <= load_word;
        end else if (shift) begin
            shadow_q <= shadow_q >> 1;
        end
    end

    assign sbit = shadow_q[0];

endmodule

// File: rtl/hash_sequencer.sv
// Sequencer for one hash operation: clear, config, absorb, warm-up, squeeze.
// Build option: HASH_SEQ_LEN_PAD_EN inserts a PAD phase after absorb.
module hash_sequencer
    import hash_seq_pkg::*;
#(
    parameter int CFG_W  = CFG_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    hash_seq_if.slave        host,
    output logic             core_clear,
    output logic             core_enable,
    output logic             cfg_shift_en,
    output logic             cfg_shift_bit,
    output logic             inj_bit,
    input  logic [OUT_W-1:0] core_out
);

    localparam logic [PHASE_W-1:0] CFG_LAST  = PHASE_W'(CFG_W - 1);
    localparam logic [PHASE_W-1:0] WARM_LAST = PHASE_W'(WARMUP - 1);

`ifdef HASH_SEQ_LEN_PAD_EN
    localparam logic [PHASE_W-1:0] PAD_LAST = PHASE_W'(LEN_W);
    localparam state_e ABSORB_EXIT = ST_PAD;
`else
    localparam state_e ABSORB_EXIT = ST_WARMUP;
`endif

    state_e             state_q;
    state_e             state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [LEN_W-1:0]   count_q;
    logic [OUT_W-1:0]   digest_q;
    logic               dvalid_q;
    logic               accept;
    logic               msg_hs;
    logic               msg_ready;
    logic               shadow_bit;

    assign accept = (state_q == ST_IDLE) && host.start;
    assign msg_hs = (state_q == ST_ABSORB) && host.msg_valid;

    hash_seq_shifter #(
        .CFG_W (CFG_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (reset),
        .load      (accept),
        .load_word (host.cfg_word),
        .shift     (state_q == ST_CONFIG),
        .sbit      (shadow_bit)
    );

`ifdef HASH_SEQ_LEN_PAD_EN
    // PAD emits a marker 1, then the absorbed length LSB first.
    logic [PHASE_W-1:0] pad_idx;
    logic [LEN_W-1:0]   pad_sh;
    logic               pad_bit;

    assign pad_idx = phase_q - PHASE_W'(1);
    assign pad_sh  = count_q >> pad_idx;
    assign pad_bit = (phase_q == '0) ? 1'b1 : pad_sh[0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (host.start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (phase_q == CFG_LAST) state_d = ST_ABSORB;
            end
            ST_ABSORB: begin
                if (msg_hs && host.msg_last) state_d = ABSORB_EXIT;
            end
`ifdef HASH_SEQ_LEN_PAD_EN
            ST_PAD: begin
                if (phase_q == PAD_LAST) state_d = ST_WARMUP;
            end
`endif
            ST_WARMUP: begin
                if (phase_q == WARM_LAST) state_d = ST_SQUEEZE;
            end
            ST_SQUEEZE: begin
                if (dvalid_q && host.digest_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        core_clear    = 1'b0;
        core_enable   = 1'b0;
        cfg_shift_en  = 1'b0;
        cfg_shift_bit = 1'b0;
        inj_bit       = 1'b0;
        msg_ready     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                core_clear = 1'b1;
            end
            ST_CONFIG: begin
                cfg_shift_en  = 1'b1;
                cfg_shift_bit = shadow_bit;
            end
            ST_ABSORB: begin
                msg_ready   = 1'b1;
                core_enable = host.msg_valid;
                inj_bit     = host.msg_valid & host.msg_bit;
            end
`ifdef HASH_SEQ_LEN_PAD_EN
            ST_PAD: begin
                core_enable = 1'b1;
                inj_bit     = pad_bit;
            end
`endif
            ST_WARMUP: begin
                core_enable = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shared phase counter restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (state_d != state_q) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= '0;
        end else if (msg_hs && (count_q != '1)) begin
            count_q <= count_q + LEN_W'(1);
        end
    end

    // Capture one cycle into SQUEEZE so the last warm-up step is included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else if (state_q == ST_SQUEEZE) begin
            if (!dvalid_q) begin
                digest_q <= core_out;
                dvalid_q <= 1'b1;
            end else if (host.digest_ready) begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign host.busy         = (state_q != ST_IDLE);
    assign host.msg_ready    = msg_ready;
    assign host.digest       = digest_q;
    assign host.digest_valid = dvalid_q;
    assign host.bit_count    = count_q;

endmodule

// File: tb/tb_hash_sequencer.sv
// Randomized scoreboard bench for hash_sequencer with a stand-in hash core.
module tb_hash_sequencer;
    import hash_seq_pkg::*;

    localparam int CFG_W  = 32;
    localparam int OUT_W  = 32;
    localparam int WARMUP = 64;
    localparam int LEN_W  = 16;
`ifdef HASH_SEQ_LEN_PAD_EN
    localparam int PADN = LEN_W + 1;
`else
    localparam int PADN = 0;
`endif
    localparam int BASE_LAT = 2 + CFG_W + WARMUP + PADN;

    typedef struct {
        logic [OUT_W-1:0] dig;
        logic [LEN_W-1:0] cnt;
        int               lat;
        logic [CFG_W-1:0] cfg;
        logic [LEN_W:0]   pad;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             core_clear;
    logic             core_enable;
    logic             cfg_shift_en;
    logic             cfg_shift_bit;
    logic             inj_bit;
    logic [OUT_W-1:0] core_out;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    exp_t             sb_q[$];

    hash_seq_if #(.CFG_W(CFG_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) hif ();

    hash_sequencer #(
        .CFG_W  (CFG_W),
        .OUT_W  (OUT_W),
        .WARMUP (WARMUP),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .host          (hif),
        .core_clear    (core_clear),
        .core_enable   (core_enable),
        .cfg_shift_en  (cfg_shift_en),
        .cfg_shift_bit (cfg_shift_bit),
        .inj_bit       (inj_bit),
        .core_out      (core_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: config chain plus a feedback register stepped on enable.
    function automatic logic [OUT_W-1:0] step(input logic [OUT_W-1:0] s,
                                              input logic [CFG_W-1:0] c,
                                              input logic b);
        logic [OUT_W-1:0] n;
        n = {s[OUT_W-2:0], s[OUT_W-1] ^ b};
        if (s[0]) n = n ^ c;
        return n;
    endfunction

    logic [CFG_W-1:0] chain_q;
    logic [OUT_W-1:0] lfsr_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            lfsr_q  <= '0;
        end else begin
            if (core_clear) lfsr_q <= '0;
            else if (core_enable) lfsr_q <= step(lfsr_q, chain_q, inj_bit);
            if (cfg_shift_en) chain_q <= {cfg_shift_bit, chain_q[CFG_W-1:1]};
        end
    end
    assign core_out = lfsr_q;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: digest = clear state stepped over message, pad, warm-up.
    function automatic exp_t model(input logic [CFG_W-1:0] cfg, input int n,
                                   input logic [63:0] msg, input int stall);
        exp_t           e;
        logic [OUT_W-1:0] s;
        logic [LEN_W:0]   pad;
        s = '0;
        for (int i = 0; i < n; i++) s = step(s, cfg, msg[i]);
        e.cnt = (n >= (1 << LEN_W)) ? '1 : LEN_W'(n);
        pad = {e.cnt, 1'b1};
        for (int i = 0; i < PADN; i++) s = step(s, cfg, pad[i]);
        for (int i = 0; i < WARMUP; i++) s = step(s, cfg, 1'b0);
        e.dig = s;
        e.lat = BASE_LAT + n + stall;
        e.cfg = cfg;
        e.pad = (PADN > 0) ? pad : '0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (hif.busy && k < 1000) begin
            tick();
            k++;
        end
        if (hif.busy) check("idle_timeout", hif.busy, 0);
    endtask

    // gap_mode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps
    task automatic run_tx(input logic [CFG_W-1:0] cfg, input int n,
                          input logic [63:0] msg, input int gap_mode,
                          input int hold, input bit dup_start,
                          input bit collide);
        int gaps[64];
        int stall = 0;
        int k = 0;
        for (int i = 0; i < n; i++) begin
            case (gap_mode)
                1:       gaps[i] = (i == 0) ? 0 : 1;
                2:       gaps[i] = $urandom_range(3, 0);
                default: gaps[i] = 0;
            endcase
            stall += gaps[i];
        end
        sb_q.push_back(model(cfg, n, msg, stall));
        wait_idle();
        hif.start    = 1'b1;
        hif.cfg_word = cfg;
        tick();
        hif.start    = 1'b0;
        hif.cfg_word = $urandom();
        while (!hif.msg_ready && k < 100) begin
            tick();
            k++;
        end
        if (!hif.msg_ready) begin
            check("absorb_timeout", hif.msg_ready, 1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            repeat (gaps[i]) begin
                hif.msg_valid = 1'b0;
                hif.msg_bit   = 1'($urandom_range(1, 0));
                hif.msg_last  = 1'($urandom_range(1, 0));
                tick();
            end
            hif.msg_valid = 1'b1;
            hif.msg_bit   = msg[i];
            hif.msg_last  = (i == n - 1);
            hif.start     = dup_start && (i == n / 2);
            tick();
            hif.msg_valid = 1'b0;
            hif.msg_last  = 1'b0;
            hif.start     = 1'b0;
        end
        k = 0;
        while (!hif.digest_valid && k < 400) begin
            tick();
            k++;
        end
        if (!hif.digest_valid) begin
            check("digest_timeout", hif.digest_valid, 1);
            return;
        end
        repeat (hold) tick();
        hif.digest_ready = 1'b1;
        hif.start        = collide;
        tick();
        hif.digest_ready = 1'b0;
        hif.start        = 1'b0;
        check("idle_after_ready", hif.busy, 0);
    endtask

    task automatic reset_mid_config();
        int k = 0;
        wait_idle();
        hif.start    = 1'b1;
        hif.cfg_word = $urandom();
        tick();
        hif.start = 1'b0;
        while (k < 10) begin
            tick();
            if (cfg_shift_en) k++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", hif.busy, 0);
        check("rst_shift_en", cfg_shift_en, 0);
        check("rst_core_en", core_enable, 0);
        check("rst_clear", core_clear, 0);
        check("rst_dvalid", hif.digest_valid, 0);
        check("rst_digest", hif.digest, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t             e;
        int               start_cyc = 0;
        int               cfg_n = 0;
        int               clr_n = 0;
        int               strobe_err = 0;
        int               post_n = 0;
        int               post_ones = 0;
        int               unstable = 0;
        logic [CFG_W-1:0] cfg_obs = '0;
        logic [LEN_W:0]   pad_obs = '0;
        logic [OUT_W-1:0] dig_hold = '0;
        logic             busy_d = 1'b0;
        logic             dv_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_d = 1'b0;
                dv_d   = 1'b0;
                continue;
            end
            if (hif.busy && !busy_d) begin
                start_cyc  = cyc;
                cfg_n      = 0;
                clr_n      = 0;
                strobe_err = 0;
                post_n     = 0;
                post_ones  = 0;
                cfg_obs    = '0;
                pad_obs    = '0;
            end
            if (core_clear) clr_n++;
            if (cfg_shift_en) begin
                if (cfg_n < CFG_W) cfg_obs[cfg_n] = cfg_shift_bit;
                cfg_n++;
                if (core_enable || hif.msg_ready) strobe_err++;
            end
            if (hif.msg_ready) begin
                if (core_enable !== hif.msg_valid) strobe_err++;
                if (inj_bit !== (hif.msg_valid & hif.msg_bit)) strobe_err++;
            end else if (core_enable) begin
                if (post_n <= LEN_W) pad_obs[post_n] = inj_bit;
                else if (inj_bit) post_ones++;
                post_n++;
            end
            if (hif.digest_valid && !dv_d) begin
                check("digest_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("digest", hif.digest, e.dig);
                    check("bit_count", hif.bit_count, e.cnt);
                    check("latency", cyc - start_cyc, e.lat);
                    check("cfg_bits", cfg_obs, e.cfg);
                    check("cfg_cycles", cfg_n, CFG_W);
                    check("clear_cycles", clr_n, 1);
                    check("strobes", strobe_err, 0);
                    check("post_cycles", post_n, WARMUP + PADN);
                    check("pad_bits", pad_obs, e.pad);
                    check("warmup_inj", post_ones, 0);
                end
                dig_hold = hif.digest;
                unstable = 0;
            end else if (hif.digest_valid && hif.digest !== dig_hold) begin
                unstable++;
            end
            if (!hif.digest_valid && dv_d) check("digest_stable", unstable, 0);
            busy_d = hif.busy;
            dv_d   = hif.digest_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int k;
        hif.start        = 1'b0;
        hif.cfg_word     = '0;
        hif.msg_valid    = 1'b0;
        hif.msg_bit      = 1'b0;
        hif.msg_last     = 1'b0;
        hif.digest_ready = 1'b0;
        #12;
        check("reset_busy", hif.busy, 0);
        check("reset_msg_ready", hif.msg_ready, 0);
        check("reset_dvalid", hif.digest_valid, 0);
        check("reset_digest", hif.digest, 0);
        check("reset_bit_count", hif.bit_count, 0);
        check("reset_strobes",
              {core_clear, core_enable, cfg_shift_en, cfg_shift_bit, inj_bit},
              0);
        tick();
        rst_n = 1'b1;
        tick();
        hif.digest_ready = 1'b1;
        tick();
        hif.digest_ready = 1'b0;
        check("idle_ready_dvalid", hif.digest_valid, 0);
        check("idle_ready_busy", hif.busy, 0);

        run_tx(32'hA5A5_0F0F, 8, 64'hB2, 0, 0, 1'b0, 1'b0);
        run_tx($urandom(), 4, {$urandom(), $urandom()}, 1, 20, 1'b0, 1'b0);
        run_tx($urandom(), 1, {$urandom(), $urandom()}, 0, 2, 1'b0, 1'b0);
        run_tx($urandom(), 3, 64'h5, 0, 1, 1'b0, 1'b0);
        run_tx($urandom(), 12, {$urandom(), $urandom()}, 2, 3, 1'b1, 1'b0);
        run_tx($urandom(), 6, {$urandom(), $urandom()}, 2, 0, 1'b0, 1'b1);
        reset_mid_config();
        run_tx($urandom(), 9, {$urandom(), $urandom()}, 0, 4, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_tx($urandom(), $urandom_range(40, 1),
                   {$urandom(), $urandom()}, $urandom_range(2, 0),
                   $urandom_range(5, 0), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)));
        end

        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check("sb_drained", sb_q.size(), 0);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_sequencer.md
Name: hash_sequencer

Overview:
- Controller that sequences one hash operation on the programmable-hash datapath (input LFSR → bent functions → output LFSR).
- Phases per request: clear core, serially load a configuration word into the LFSR config registers, absorb message bits into the input-LFSR injector, run blank warm-up cycles, then present the output-LFSR state as a digest.
- Sits between a host/message source and the hash top; owns all enable, clear, config-shift and injector strobes.

Parameters:
- CFG_W, 32, config bits shifted into the config-register chain per operation.
- OUT_W, 32, width of the output-LFSR state and of the digest.
- WARMUP, 64, blank cycles after absorb, injector forced 0; legal range 1..65535.
- LEN_W, 16, width of the absorbed-bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- cfg_word  in  CFG_W  config captured on accepted start.
- busy  out  1  high in every state except IDLE.
- msg_valid  in  1  message bit valid.
- msg_bit  in  1  message bit.
- msg_last  in  1  final message bit, qualified by msg_valid.
- msg_ready  out  1  high only in ABSORB.
- core_clear  out  1  one-cycle clear of the hash core.
- core_enable  out  1  clock-enable of both LFSRs.
- cfg_shift_en  out  1  shift enable for the config-register chain.
- cfg_shift_bit  out  1  serial config bit, LSB first.
- inj_bit  out  1  drives the input-LFSR injector.
- core_out  in  OUT_W  output-LFSR state.
- digest  out  OUT_W  registered digest.
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer accepts digest.
- bit_count  out  LEN_W  bits absorbed in the current or last operation.

Behaviour:
- Reset (async, reset=0) state:
  - State IDLE.
  - All outputs 0, including digest and bit_count.
  - Config shadow register and all counters cleared.
- Reset mid-operation: abort immediately to IDLE. No partial digest is presented.
- FSM transitions:
  - IDLE → CLEAR on start=1. cfg_word is captured into the shadow register in the same edge. bit_count is cleared to 0.
  - CLEAR, 1 cycle: core_clear=1, core_enable=0.
  - CONFIG, exactly CFG_W cycles:
    - cfg_shift_en=1 and core_enable=0.
    - cfg_shift_bit = shadow[0]; the shadow register shifts right each cycle.
    - Then go to ABSORB.
  - ABSORB:
    - msg_ready=1.
    - core_enable = msg_valid. inj_bit = msg_bit when msg_valid, else 0.
    - Each handshake increments bit_count; it saturates at all-ones.
    - A handshake with msg_last=1 goes to WARMUP, or PAD when the optional feature is enabled.
    - With no msg_valid, the FSM stalls with the core frozen.
  - WARMUP, exactly WARMUP cycles: core_enable=1, inj_bit=0. Then go to SQUEEZE.
  - SQUEEZE:
    - On entry, digest<=core_out and digest_valid=1.
    - core_enable=0, so the core is frozen.
    - Hold until digest_ready=1, then go to IDLE with digest_valid deasserted.
    - digest keeps its value until the next SQUEEZE entry.
- Latency from start to digest_valid: 2 + CFG_W + (handshaked bits, including stall cycles) + WARMUP cycles, with no stalls outside ABSORB.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as the digest_ready that returns to IDLE: ignored.
  - msg_last without msg_valid: ignored.
  - Single-bit message (msg_last on the first handshake): legal; bit_count=1.
  - Empty messages are not supported; at least one bit is always absorbed.
  - digest_ready while digest_valid=0: no effect.
- Counters: the phase counter is 16 bits, shared by CONFIG, WARMUP and PAD, and reloaded on each phase entry.

Optional Feature:
- Macro: HASH_SEQ_LEN_PAD_EN.
- Defined: ABSORB exits to PAD.
  - PAD runs LEN_W + 1 cycles, core_enable=1.
  - inj_bit = 1 on the first cycle, then bit_count LSB first.
  - PAD cycles do not increment bit_count. Then go to WARMUP.
  - Latency grows by LEN_W+1.
- Undefined: PAD state and its logic are absent; ABSORB goes straight to WARMUP.

Decomposition:
- Shared package (hash_seq_pkg):
  - State enum: IDLE, CLEAR, CONFIG, ABSORB, PAD, WARMUP, SQUEEZE.
  - Phase-counter width constant PHASE_W=16.
  - Default values for CFG_W, OUT_W, WARMUP, LEN_W.
- One natural sub-module, hash_seq_shifter: the loadable config shadow register plus serial-out logic. The FSM and counters stay in the top.

Test Plan:
- Config shift: CFG_W=32, cfg_word=0xA5A5_0F0F, start → 32 cfg_shift_en cycles; cfg_shift_bit sequence 1,1,1,1,0,0,0,0,… (LSB first); core_enable=0 throughout.
- Message absorb: 8-bit message 0b1011_0010 with no gaps, msg_last on bit 8 → inj_bit mirrors each bit; bit_count=8; digest_valid exactly 2+32+8+64=106 cycles after start.
- Stall and back-pressure:
  - msg_valid toggling 1,0,1,0 → core_enable follows msg_valid; latency grows by the number of idle cycles.
  - digest_ready held low 20 cycles → digest_valid and digest stable; FSM returns to IDLE one cycle after digest_ready=1.
- Start while busy: second start during ABSORB → ignored; exactly one digest produced; cfg shadow unchanged.
- Reset mid-CONFIG: reset=0 at cycle 10 of CONFIG → busy=0, all strobes 0 immediately (asynchronous), digest_valid=0. A new start afterwards completes normally.
- Length padding (HASH_SEQ_LEN_PAD_EN defined, LEN_W=16): 3-bit message → 17 PAD cycles with inj_bit = 1, then 1,1,0,0,…,0 (count 3 LSB first); latency +17.
